crc_lane_checker: RTL and testbench

CRC_LANE_CHECKER -- requirements
Module: crc_lane_checker

---
 rtl/crc_lane_checker_pkg.sv | 13 +
 rtl/crc_par_step.sv | 31 +++
 rtl/crc_lane_checker.sv | 126 ++++++++++++
 tb/tb_crc_lane_checker.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/crc_lane_checker_pkg.sv
// Shared types and constants for the multi-lane CRC checker.
// Frame states come from the upstream framer; the default polynomial is x^10+x^9+x^5+x^4+x+1.
package crc_lane_checker_pkg;

    typedef enum logic [1:0] {
        IDLEB     = 2'd0,
        DATA      = 2'd1,
        DATA_TAIL = 2'd2
    } frame_state_t;

    localparam logic [9:0] CRC_POLY_DEFAULT = 10'h233;

endpackage

// File: rtl/crc_par_step.sv
// One-cycle parallel CRC update: folds DATA_W bits (MSB first) into the CRC,
// non-reflected, as an unrolled serial LFSR. Purely combinational.
module crc_par_step
    import crc_lane_checker_pkg::*;
#(
    parameter int                 CRC_W  = 10,
    parameter int                 DATA_W = 16,
    parameter logic [CRC_W-1:0]   POLY   = CRC_POLY_DEFAULT
) (
    input  logic [CRC_W-1:0]  crc_in,
    input  logic [DATA_W-1:0] data,
    output logic [CRC_W-1:0]  crc_out
);

    logic [CRC_W-1:0] crc_work;
    logic             feedback;

    always_comb begin
        crc_work = crc_in;
        feedback = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            feedback = crc_work[CRC_W-1] ^ data[i];
            crc_work = {crc_work[CRC_W-2:0], 1'b0};
            if (feedback) begin
                crc_work = crc_work ^ POLY;
            end
        end
        crc_out = crc_work;
    end

endmodule

// File: rtl/crc_lane_checker.sv
// Per-lane CRC check of framed payload with packet/error statistics and a
// consecutive-failure link alarm. Results appear one cycle after each tail.
module crc_lane_checker
    import crc_lane_checker_pkg::*;
#(
    parameter int               NUM_LANES    = 4,
    parameter int               LANE_W       = 16,
    parameter int               CRC_W        = 10,
    parameter logic [CRC_W-1:0] CRC_POLY     = CRC_POLY_DEFAULT,
    parameter int               CNT_W        = 22,
    parameter int               ALARM_THRESH = 8
) (
    input  logic                          clk_390p625M,
    input  logic                          rst_n,
    input  frame_state_t                  frame_state,
    input  logic [NUM_LANES*LANE_W-1:0]   data_in,
    input  logic [NUM_LANES*CRC_W-1:0]    crc_rx,
    input  logic                          cnt_clear,
    output logic                          check_result,
    output logic [NUM_LANES-1:0]          lane_err,
    output logic                          result_valid,
    output logic [CNT_W-1:0]              error_packet_cnt,
    output logic [CNT_W-1:0]              total_packet_cnt,
    output logic                          link_alarm
);

    localparam int CONSEC_W = $clog2(ALARM_THRESH + 1);
    localparam logic [CONSEC_W-1:0] CONSEC_MAX = CONSEC_W'(ALARM_THRESH);

    logic                  in_data;
    logic                  in_tail;
    logic [NUM_LANES-1:0]  lane_fail;
    logic                  any_fail;
    logic [CONSEC_W-1:0]   consec_fail_reg;

    // Unknown encodings fall into the default arm and behave like IDLEB.
    always_comb begin
        in_data = 1'b0;
        in_tail = 1'b0;
        case (frame_state)
            DATA:      in_data = 1'b1;
            DATA_TAIL: in_tail = 1'b1;
            default:   ;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [CRC_W-1:0] crc_reg;
            logic [CRC_W-1:0] crc_next;

            crc_par_step #(
                .CRC_W  (CRC_W),
                .DATA_W (LANE_W),
                .POLY   (CRC_POLY)
            ) u_step (
                .crc_in  (crc_reg),
                .data    (data_in[gi*LANE_W +: LANE_W]),
                .crc_out (crc_next)
            );

            assign lane_fail[gi] = in_tail && (crc_next != crc_rx[gi*CRC_W +: CRC_W]);

            // Accumulate only through DATA; tails and idle restart from zero.
            always_ff @(posedge clk_390p625M or negedge rst_n) begin
                if (!rst_n) begin
                    crc_reg <= '0;
                end else if (in_data) begin
                    crc_reg <= crc_next;
                end else begin
                    crc_reg <= '0;
                end
            end
        end
    endgenerate

    assign any_fail = |lane_fail;

    always_ff @(posedge clk_390p625M or negedge rst_n) begin
        if (!rst_n) begin
            lane_err     <= '0;
            check_result <= 1'b1;
            result_valid <= 1'b0;
        end else begin
            result_valid <= in_tail;
            if (in_tail) begin
                lane_err     <= lane_fail;
                check_result <= ~any_fail;
            end
        end
    end

    // A window-overflow clear wins over a coincident tail for the statistics.
    always_ff @(posedge clk_390p625M or negedge rst_n) begin
        if (!rst_n) begin
            total_packet_cnt <= '0;
            error_packet_cnt <= '0;
        end else if (cnt_clear) begin
            total_packet_cnt <= '0;
            error_packet_cnt <= '0;
        end else if (in_tail) begin
            if (total_packet_cnt != {CNT_W{1'b1}}) begin
                total_packet_cnt <= total_packet_cnt + CNT_W'(1);
            end
            if (any_fail && (error_packet_cnt != {CNT_W{1'b1}})) begin
                error_packet_cnt <= error_packet_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_390p625M or negedge rst_n) begin
        if (!rst_n) begin
            consec_fail_reg <= '0;
        end else if (in_tail) begin
            if (!any_fail) begin
                consec_fail_reg <= '0;
            end else if (consec_fail_reg != CONSEC_MAX) begin
                consec_fail_reg <= consec_fail_reg + CONSEC_W'(1);
            end
        end
    end

    assign link_alarm = (consec_fail_reg == CONSEC_MAX);

endmodule

// File: tb/tb_crc_lane_checker.sv
// Directed checks of crc_lane_checker (4 lanes x 16b, CRC-10 0x233, CNT_W=4,
// ALARM_THRESH=3) plus random frames checked against a long-division CRC.
module tb_crc_lane_checker;
    import crc_lane_checker_pkg::*;

    localparam int NL = 4;
    localparam int LW = 16;
    localparam int CW = 10;

    logic                clk_390p625M;
    logic                rst_n;
    frame_state_t        frame_state;
    logic [NL*LW-1:0]    data_in;
    logic [NL*CW-1:0]    crc_rx;
    logic                cnt_clear;
    logic                check_result;
    logic [NL-1:0]       lane_err;
    logic                result_valid;
    logic [3:0]          error_packet_cnt;
    logic [3:0]          total_packet_cnt;
    logic                link_alarm;

    int n_checks = 0;
    int n_errors = 0;

    crc_lane_checker #(
        .NUM_LANES    (NL),
        .LANE_W       (LW),
        .CRC_W        (CW),
        .CRC_POLY     (10'h233),
        .CNT_W        (4),
        .ALARM_THRESH (3)
    ) dut (
        .clk_390p625M     (clk_390p625M),
        .rst_n            (rst_n),
        .frame_state      (frame_state),
        .data_in          (data_in),
        .crc_rx           (crc_rx),
        .cnt_clear        (cnt_clear),
        .check_result     (check_result),
        .lane_err         (lane_err),
        .result_valid     (result_valid),
        .error_packet_cnt (error_packet_cnt),
        .total_packet_cnt (total_packet_cnt),
        .link_alarm       (link_alarm)
    );

    initial clk_390p625M = 1'b0;
    always #5 clk_390p625M = ~clk_390p625M;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs (called on a negedge, returns on the next one).
    task automatic step(input frame_state_t fs, input logic [63:0] d,
                        input logic [39:0] c, input logic clr);
        frame_state = fs;
        data_in     = d;
        crc_rx      = c;
        cnt_clear   = clr;
        @(negedge clk_390p625M);
        if (fs == DATA_TAIL)
            $display("tail: lane_err=%b check_result=%0d total=%0d errors=%0d alarm=%0d",
                     lane_err, check_result, total_packet_cnt, error_packet_cnt, link_alarm);
    endtask

    // Reference: remainder of msg * x^10 divided by x^10+x^9+x^5+x^4+x+1.
    function automatic logic [9:0] ref_crc(input logic [63:0] msg);
        logic [73:0] r;
        r = {msg, 10'b0};
        for (int i = 73; i >= 10; i--) begin
            if (r[i]) r[i -: 11] = r[i -: 11] ^ 11'h633;
        end
        return r[9:0];
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] w [4];
        logic [63:0] msg;
        logic [39:0] crc_vec;
        logic [3:0]  mask;

        rst_n = 1'b0;
        frame_state = IDLEB;
        data_in = '0;
        crc_rx = '0;
        cnt_clear = 1'b0;
        @(negedge clk_390p625M);
        @(negedge clk_390p625M);
        check_eq("rst_check_result", check_result, 1);
        check_eq("rst_lane_err", lane_err, 0);
        check_eq("rst_result_valid", result_valid, 0);
        check_eq("rst_err_cnt", error_packet_cnt, 0);
        check_eq("rst_total_cnt", total_packet_cnt, 0);
        check_eq("rst_alarm", link_alarm, 0);
        rst_n = 1'b1;
        step(IDLEB, 0, 0, 0);

        // Zero payload, zero CRC: passes.
        repeat (3) step(DATA, 0, 0, 0);
        step(DATA_TAIL, 0, 0, 0);
        check_eq("zero_valid", result_valid, 1);
        check_eq("zero_result", check_result, 1);
        check_eq("zero_lane_err", lane_err, 0);
        check_eq("zero_total", total_packet_cnt, 1);
        check_eq("zero_err", error_packet_cnt, 0);
        step(IDLEB, 0, 0, 0);
        check_eq("valid_pulse_end", result_valid, 0);
        check_eq("result_hold", check_result, 1);

        // Same frame, lane 2 CRC bit 0 flipped.
        repeat (3) step(DATA, 0, 0, 0);
        step(DATA_TAIL, 0, 40'h1 << 20, 0);
        check_eq("lane2_lane_err", lane_err, 4'b0100);
        check_eq("lane2_result", check_result, 0);
        check_eq("lane2_err_cnt", error_packet_cnt, 1);
        check_eq("lane2_total", total_packet_cnt, 2);
        step(IDLEB, 0, 0, 0);
        check_eq("lane_err_hold", lane_err, 4'b0100);

        // Hand-computed single-word packets: 0x0001 -> 0x233, 0x0002 -> 0x255.
        step(DATA_TAIL, 64'h0000_0000_0002_0001, {10'h0, 10'h0, 10'h255, 10'h233}, 0);
        check_eq("hand_result", check_result, 1);
        check_eq("hand_lane_err", lane_err, 0);

        // Three back-to-back failing tails raise the alarm; a pass clears it.
        step(DATA_TAIL, 0, 40'h1, 0);
        check_eq("alarm_after1", link_alarm, 0);
        step(DATA_TAIL, 0, 40'h1, 0);
        check_eq("alarm_after2", link_alarm, 0);
        step(DATA_TAIL, 0, 40'h1, 0);
        check_eq("alarm_after3", link_alarm, 1);
        check_eq("alarm_lane_err", lane_err, 4'b0001);
        step(DATA_TAIL, 64'h0000_0000_0000_0001, 40'h233, 0);
        check_eq("alarm_cleared", link_alarm, 0);
        check_eq("b2b_tail_result", check_result, 1);
        check_eq("alarm_total", total_packet_cnt, 7);
        check_eq("alarm_err", error_packet_cnt, 4);

        // Encoding 3 acts as IDLEB and discards accumulated CRC.
        step(DATA, 64'h1234_5678_9abc_def0, 0, 0);
        step(frame_state_t'(2'b11), 64'hffff_ffff_ffff_ffff, 0, 0);
        step(DATA_TAIL, 64'h0000_0000_0000_0001, 40'h233, 0);
        check_eq("bad_state_result", check_result, 1);

        // Clear coincident with a failing tail.
        step(DATA_TAIL, 0, 40'h1, 0);
        step(DATA_TAIL, 0, 40'h1, 0);
        step(DATA_TAIL, 0, 40'h1 << 30, 1);
        check_eq("clr_err_cnt", error_packet_cnt, 0);
        check_eq("clr_total", total_packet_cnt, 0);
        check_eq("clr_lane_err", lane_err, 4'b1000);
        check_eq("clr_alarm", link_alarm, 1);

        // Saturation with 4-bit counters.
        repeat (20) step(DATA_TAIL, 0, 40'h1, 0);
        check_eq("sat_err", error_packet_cnt, 15);
        check_eq("sat_total", total_packet_cnt, 15);
        step(DATA_TAIL, 0, 0, 0);
        check_eq("sat_total_hold", total_packet_cnt, 15);
        check_eq("sat_err_hold", error_packet_cnt, 15);
        check_eq("sat_alarm_off", link_alarm, 0);

        // Reset mid-DATA, then a frame with no IDLEB in between.
        step(DATA, 64'hdead_beef_cafe_f00d, 0, 0);
        step(DATA, 64'h0123_4567_89ab_cdef, 0, 0);
        rst_n = 1'b0;
        #2;
        check_eq("midrst_total", total_packet_cnt, 0);
        check_eq("midrst_result", check_result, 1);
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < 4; k++) w[k] = {$urandom, $urandom};
            mask = (f == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            for (int l = 0; l < NL; l++) begin
                msg = {w[0][l*LW +: LW], w[1][l*LW +: LW], w[2][l*LW +: LW], w[3][l*LW +: LW]};
                crc_vec[l*CW +: CW] = ref_crc(msg) ^ (mask[l] ? 10'($urandom_range(1, 1023)) : 10'h0);
            end
            if (f == 0) begin
                frame_state = DATA;
                data_in = w[0];
                rst_n = 1'b1;
                @(negedge clk_390p625M);
            end else begin
                step(IDLEB, 0, 0, 0);
                step(DATA, w[0], 0, 0);
            end
            step(DATA, w[1], 0, 0);
            step(DATA, w[2], 0, 0);
            step(DATA_TAIL, w[3], crc_vec, 0);
            check_eq($sformatf("rand%0d_lane_err", f), lane_err, mask);
            check_eq($sformatf("rand%0d_result", f), check_result, (mask == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
